// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 commutation step sequencer:
// the sequencer states, the step index constants and the step-order helpers.
package motoro3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } seqState_t;

  localparam logic [3:0] STEP_IDLE  = 4'd15;
  localparam logic [3:0] STEP_FIRST = 4'd0;
  localparam logic [3:0] STEP_MAX   = 4'd11;

  // Last step before a winding polarity change, per direction
  localparam logic [3:0] FWD_POL_A = 4'd5;
  localparam logic [3:0] FWD_POL_B = 4'd11;
  localparam logic [3:0] REV_POL_A = 4'd6;
  localparam logic [3:0] REV_POL_B = 4'd0;

  function automatic logic [3:0] advanceStep(input logic [3:0] step, input logic rev);
    logic [3:0] nxt;
    if (rev) begin
      nxt = (step == STEP_FIRST) ? STEP_MAX : step - 4'd1;
    end else begin
      nxt = (step >= STEP_MAX) ? STEP_FIRST : step + 4'd1;
    end
    return nxt;
  endfunction

  function automatic logic isPolarityStep(input logic [3:0] step, input logic rev);
    logic hit;
    if (rev) begin
      hit = (step == REV_POL_A) || (step == REV_POL_B);
    end else begin
      hit = (step == FWD_POL_A) || (step == FWD_POL_B);
    end
    return hit;
  endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// Request/status bundle between the motor controller and the step sequencer.
interface motoro3_step_sequencer_if #(
  parameter int PERIOD_W = 25
);
  logic                m3r_runEn;
  logic                m3r_dirRev;
  logic [PERIOD_W-1:0] m3r_stepPeriod;
  logic [15:0]         m3r_pwmLenPos;
  logic [3:0]          sgStep;
  logic [PERIOD_W-1:0] m3cnt;
  logic                m3cntFirst2;
  logic                m3cntFirst1;
  logic                m3cntLast2;
  logic                m3cntLast1;
  logic                pwmActive1;
  logic                pwmLastStep1;
  logic [15:0]         pwmLENpos;

  modport master (
    output m3r_runEn, m3r_dirRev, m3r_stepPeriod, m3r_pwmLenPos,
    input  sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
           pwmActive1, pwmLastStep1, pwmLENpos
  );

  modport slave (
    input  m3r_runEn, m3r_dirRev, m3r_stepPeriod, m3r_pwmLenPos,
    output sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
           pwmActive1, pwmLastStep1, pwmLENpos
  );
endinterface

// File: rtl/motoro3_step_timer.sv
// Per-step down counter for the motoro3 sequencer; clamps the requested period
// to MIN_PERIOD and latches it only when a new step is loaded.
module motoro3_step_timer #(
  parameter int PERIOD_W   = 25,
  parameter int MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] stepPeriod,
  output logic [PERIOD_W-1:0] cnt,
  output logic [PERIOD_W-1:0] peffLatched,
  output logic                cntZero
);

  logic [PERIOD_W-1:0] peff_s;
  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] peff_r;

  // Effective period clamp
  always_comb begin
    if (stepPeriod < PERIOD_W'(MIN_PERIOD)) begin
      peff_s = PERIOD_W'(MIN_PERIOD);
    end else begin
      peff_s = stepPeriod;
    end
  end

  // Counter and latched period; the counter parks at zero once a step is not reloaded
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= PERIOD_W'(0);
      peff_r <= PERIOD_W'(MIN_PERIOD);
    end else if (load) begin
      cnt_r  <= peff_s - PERIOD_W'(1);
      peff_r <= peff_s;
    end else if (cnt_r != PERIOD_W'(0)) begin
      cnt_r  <= cnt_r - PERIOD_W'(1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  assign cnt         = cnt_r;
  assign peffLatched = peff_r;
  assign cntZero     = (cnt_r == PERIOD_W'(0));

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Motor commutation step sequencer: IDLE/RUN/STOP control of a 12-step cycle.
// Reverse step order is available only when MOTORO3_SEQ_REVERSE_EN is defined.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int PERIOD_W   = 25,
  parameter int MIN_PERIOD = 4
) (
  input logic                     clk,
  input logic                     rst,
  motoro3_step_sequencer_if.slave bus
);

  seqState_t           state_r;
  seqState_t           nextState_s;
  logic [3:0]          sgStep_r;
  logic [15:0]         pwmLENpos_r;
  logic                dirLatched_r;
  logic                dirSel_s;
  logic                loadStep_s;
  logic [PERIOD_W-1:0] cnt_s;
  logic [PERIOD_W-1:0] peffLatched_s;
  logic                cntZero_s;
  logic                active_s;
  logic                first2_s;
  logic                first1_s;
  logic                last2_s;
  logic                last1_s;
  logic                lastStep_s;

  // Direction request as seen by this build
  always_comb begin
`ifdef MOTORO3_SEQ_REVERSE_EN
    dirSel_s = bus.m3r_dirRev;
`else
    dirSel_s = bus.m3r_dirRev & 1'b0;
`endif
  end

  motoro3_step_timer #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) uTimer (
    .clk         (clk),
    .rst         (rst),
    .load        (loadStep_s),
    .stepPeriod  (bus.m3r_stepPeriod),
    .cnt         (cnt_s),
    .peffLatched (peffLatched_s),
    .cntZero     (cntZero_s)
  );

  // State register
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next state and step-load decision; STOP only ends at a step boundary
  always_comb begin
    nextState_s = state_r;
    loadStep_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.m3r_runEn) begin
          nextState_s = RUN;
          loadStep_s  = 1'b1;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        nextState_s = bus.m3r_runEn ? RUN : STOP;
        loadStep_s  = cntZero_s;
      end
      STOP: begin
        if (bus.m3r_runEn) begin
          nextState_s = RUN;
          loadStep_s  = cntZero_s;
        end else if (cntZero_s) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = STOP;
        end
      end
      default: begin
        nextState_s = IDLE;
        loadStep_s  = 1'b0;
      end
    endcase
  end

  // Step index, direction and on-length are captured together at each step load
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sgStep_r     <= STEP_IDLE;
      dirLatched_r <= 1'b0;
      pwmLENpos_r  <= 16'h0000;
    end else if (loadStep_s) begin
      dirLatched_r <= dirSel_s;
      pwmLENpos_r  <= bus.m3r_pwmLenPos;
      if (state_r == IDLE) begin
        sgStep_r <= dirSel_s ? STEP_MAX : STEP_FIRST;
      end else begin
        sgStep_r <= advanceStep(sgStep_r, dirSel_s);
      end
    end else if (nextState_s == IDLE) begin
      sgStep_r <= STEP_IDLE;
    end else begin
      sgStep_r <= sgStep_r;
    end
  end

  // Outputs decoded from state and counter
  always_comb begin
    active_s   = (state_r != IDLE);
    first2_s   = active_s && (cnt_s == peffLatched_s - PERIOD_W'(1));
    first1_s   = active_s && (cnt_s == peffLatched_s - PERIOD_W'(2));
    last2_s    = active_s && (cnt_s == PERIOD_W'(1));
    last1_s    = active_s && (cnt_s == PERIOD_W'(0));
    lastStep_s = active_s && isPolarityStep(sgStep_r, dirLatched_r);
  end

  assign bus.sgStep       = sgStep_r;
  assign bus.m3cnt        = cnt_s;
  assign bus.m3cntFirst2  = first2_s;
  assign bus.m3cntFirst1  = first1_s;
  assign bus.m3cntLast2   = last2_s;
  assign bus.m3cntLast1   = last1_s;
  assign bus.pwmActive1   = active_s;
  assign bus.pwmLastStep1 = lastStep_s;
  assign bus.pwmLENpos    = pwmLENpos_r;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed self-checking bench for motoro3_step_sequencer; the expected step
// order follows MOTORO3_SEQ_REVERSE_EN in the same way the design does.
module tb_motoro3_step_sequencer;

  localparam int PERIOD_W = 25;
`ifdef MOTORO3_SEQ_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   nChecks;
  int   nBad;

  motoro3_step_sequencer_if #(.PERIOD_W(PERIOD_W)) busIf ();

  motoro3_step_sequencer #(.PERIOD_W(PERIOD_W), .MIN_PERIOD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sample point: half a cycle after the falling (active) edge
  task automatic nextSample();
    @(posedge clk);
    #1;
  endtask

  task automatic runSamples(input int n);
    for (int i = 0; i < n; i++) nextSample();
  endtask

  function automatic logic [5:0] strobeVec();
    return {busIf.m3cntFirst2, busIf.m3cntFirst1, busIf.m3cntLast2,
            busIf.m3cntLast1, busIf.pwmActive1, busIf.pwmLastStep1};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int expStep;
    logic expLast;
    nChecks = 0;
    nBad    = 0;
    rst                  = 1'b0;
    busIf.m3r_runEn      = 1'b0;
    busIf.m3r_dirRev     = 1'b0;
    busIf.m3r_stepPeriod = 25'd10;
    busIf.m3r_pwmLenPos  = 16'h1234;
    #10 rst = 1'b1;
    #20;
    checkVal("rst_step", busIf.sgStep, 32'd15);
    checkVal("rst_cnt", busIf.m3cnt, 32'd0);
    checkVal("rst_strobes", strobeVec(), 32'd0);
    checkVal("rst_len", busIf.pwmLENpos, 32'd0);

    // First step, forward, period 10
    nextSample();
    nextSample();
    rst = 1'b0;
    busIf.m3r_runEn = 1'b1;
    nextSample();
    for (int k = 9; k >= 0; k--) begin
      checkVal("s0_step", busIf.sgStep, 32'd0);
      checkVal("s0_cnt", busIf.m3cnt, k);
      checkVal("s0_first2", busIf.m3cntFirst2, (k == 9));
      checkVal("s0_first1", busIf.m3cntFirst1, (k == 8));
      checkVal("s0_last2", busIf.m3cntLast2, (k == 1));
      checkVal("s0_last1", busIf.m3cntLast1, (k == 0));
      checkVal("s0_active", busIf.pwmActive1, 32'd1);
      nextSample();
    end
    checkVal("s1_step", busIf.sgStep, 32'd1);
    checkVal("s1_cnt", busIf.m3cnt, 32'd9);
    checkVal("s1_len", busIf.pwmLENpos, 32'h1234);

    // Full cycle to the wrap; on-length changed mid-step 1 shows up from step 2
    busIf.m3r_pwmLenPos = 16'h5555;
    for (int s = 1; s <= 11; s++) begin
      for (int k = 9; k >= 0; k--) begin
        checkVal("cyc_step", busIf.sgStep, s);
        checkVal("cyc_last", busIf.pwmLastStep1, (s == 5) || (s == 11));
        if (k == 5) checkVal("cyc_len", busIf.pwmLENpos, (s == 1) ? 32'h1234 : 32'h5555);
        nextSample();
      end
    end
    checkVal("wrap_step", busIf.sgStep, 32'd0);
    checkVal("wrap_cnt", busIf.m3cnt, 32'd9);
    checkVal("wrap_last", busIf.pwmLastStep1, 32'd0);

    // Period change mid-step applies at the next load; small periods clamp to 4
    busIf.m3r_stepPeriod = 25'd20;
    runSamples(10);
    checkVal("p20_step", busIf.sgStep, 32'd1);
    checkVal("p20_cnt", busIf.m3cnt, 32'd19);
    checkVal("p20_first2", busIf.m3cntFirst2, 32'd1);
    busIf.m3r_stepPeriod = 25'd2;
    runSamples(19);
    checkVal("p20_end_step", busIf.sgStep, 32'd1);
    checkVal("p20_end_last1", busIf.m3cntLast1, 32'd1);
    nextSample();
    checkVal("p4_step", busIf.sgStep, 32'd2);
    checkVal("p4_cnt", busIf.m3cnt, 32'd3);
    checkVal("p4_first2", busIf.m3cntFirst2, 32'd1);
    nextSample();
    checkVal("p4_first1", busIf.m3cntFirst1, 32'd1);
    nextSample();
    checkVal("p4_last2", busIf.m3cntLast2, 32'd1);
    nextSample();
    checkVal("p4_last1", busIf.m3cntLast1, 32'd1);
    nextSample();
    checkVal("p4b_step", busIf.sgStep, 32'd3);
    checkVal("p4b_cnt", busIf.m3cnt, 32'd3);
    busIf.m3r_stepPeriod = 25'd10;
    runSamples(4);
    checkVal("p10_step", busIf.sgStep, 32'd4);
    checkVal("p10_cnt", busIf.m3cnt, 32'd9);

    // Stop request at cnt 6: step completes, then idle
    runSamples(3);
    checkVal("stop_at", busIf.m3cnt, 32'd6);
    busIf.m3r_runEn = 1'b0;
    nextSample();
    for (int k = 5; k >= 0; k--) begin
      checkVal("stop_cnt", busIf.m3cnt, k);
      checkVal("stop_active", busIf.pwmActive1, 32'd1);
      checkVal("stop_step", busIf.sgStep, 32'd4);
      nextSample();
    end
    checkVal("idle_step", busIf.sgStep, 32'd15);
    checkVal("idle_cnt", busIf.m3cnt, 32'd0);
    checkVal("idle_strobes", strobeVec(), 32'd0);
    checkVal("idle_len", busIf.pwmLENpos, 32'h5555);

    // Restart, drop at cnt 7, re-raise at cnt 3: no idle cycle
    busIf.m3r_runEn = 1'b1;
    nextSample();
    checkVal("rs_step", busIf.sgStep, 32'd0);
    checkVal("rs_cnt", busIf.m3cnt, 32'd9);
    runSamples(2);
    busIf.m3r_runEn = 1'b0;
    runSamples(4);
    checkVal("rs_cnt3", busIf.m3cnt, 32'd3);
    busIf.m3r_runEn = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      nextSample();
      checkVal("rs_active", busIf.pwmActive1, 32'd1);
      checkVal("rs_cnt_k", busIf.m3cnt, k);
    end
    nextSample();
    checkVal("rs_next_step", busIf.sgStep, 32'd1);
    checkVal("rs_next_active", busIf.pwmActive1, 32'd1);

    // Direction request: reverse order only in builds with the reverse feature
    busIf.m3r_runEn = 1'b0;
    runSamples(10);
    checkVal("dir_idle", busIf.sgStep, 32'd15);
    busIf.m3r_dirRev = 1'b1;
    busIf.m3r_runEn  = 1'b1;
    nextSample();
    for (int i = 0; i < 12; i++) begin
      expStep = REV_EN ? (11 - i) : i;
      expLast = REV_EN ? ((expStep == 6) || (expStep == 0)) : ((expStep == 5) || (expStep == 11));
      for (int k = 9; k >= 0; k--) begin
        if (k == 9 || k == 0) begin
          checkVal("dir_step", busIf.sgStep, expStep);
          checkVal("dir_last", busIf.pwmLastStep1, expLast);
        end
        nextSample();
      end
    end
    checkVal("dir_wrap", busIf.sgStep, REV_EN ? 32'd11 : 32'd0);

    // Reset pulse mid-step 3 at cnt 5
    busIf.m3r_runEn  = 1'b0;
    busIf.m3r_dirRev = 1'b0;
    runSamples(10);
    busIf.m3r_runEn = 1'b1;
    nextSample();
    runSamples(34);
    checkVal("pre_rst_step", busIf.sgStep, 32'd3);
    checkVal("pre_rst_cnt", busIf.m3cnt, 32'd5);
    #20 rst = 1'b1;
    #1;
    checkVal("arst_step", busIf.sgStep, 32'd15);
    checkVal("arst_cnt", busIf.m3cnt, 32'd0);
    checkVal("arst_len", busIf.pwmLENpos, 32'd0);
    for (int j = 0; j < 6; j++) begin
      checkVal("arst_strobes", strobeVec(), 32'd0);
      #10;
    end
    busIf.m3r_runEn = 1'b0;
    nextSample();
    rst = 1'b0;
    runSamples(2);
    checkVal("post_rst_idle", busIf.sgStep, 32'd15);
    checkVal("post_rst_active", busIf.pwmActive1, 32'd0);
    busIf.m3r_runEn = 1'b1;
    nextSample();
    checkVal("post_rst_step", busIf.sgStep, 32'd0);
    checkVal("post_rst_cnt", busIf.m3cnt, 32'd9);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
